// File: rtl/nibble_add_sequencer_if.sv
// Operand/result handshake bundle for nibble_add_sequencer.
// The op_sub signal exists only when NAS_SUB_EN is defined.
interface nibble_add_sequencer_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
`ifdef NAS_SUB_EN
    logic             op_sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;

`ifdef NAS_SUB_EN
    modport slave  (input  in_valid, in_a, in_b, in_cin, op_sub, out_ready,
                    output in_ready, out_valid, out_sum, out_cout);
    modport master (output in_valid, in_a, in_b, in_cin, op_sub, out_ready,
                    input  in_ready, out_valid, out_sum, out_cout);
`else
    modport slave  (input  in_valid, in_a, in_b, in_cin, out_ready,
                    output in_ready, out_valid, out_sum, out_cout);
    modport master (output in_valid, in_a, in_b, in_cin, out_ready,
                    input  in_ready, out_valid, out_sum, out_cout);
`endif
endinterface

// File: rtl/nibble_add_sequencer.sv
// WIDTH-bit adder built by time-sharing one external 4-bit full adder,
// LSB nibble first, with the carry held in a register between passes.
// Optional feature: NAS_SUB_EN adds op_sub (A-B via ~B and carry-in 1).
module nibble_add_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    nibble_add_sequencer_if.slave bus,
    output logic [3:0]            adder_a,
    output logic [3:0]            adder_b,
    output logic                  adder_cin,
    input  logic [3:0]            adder_sum,
    input  logic                  adder_cout,
    output logic                  busy
);
    localparam int NIB = WIDTH / 4;
    localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [KW-1:0]    k;
    logic             carry;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             sub;
    logic             accept;

`ifdef NAS_SUB_EN
    assign sub = bus.op_sub;
`else
    assign sub = 1'b0;
`endif

    // in_ready is suppressed while rst is held so nothing looks accepted during reset
    assign bus.in_ready  = (state == S_IDLE) && !rst;
    assign bus.out_valid = (state == S_DONE);
    assign bus.out_sum   = sum_reg;
    assign bus.out_cout  = cout_reg;
    assign busy          = (state != S_IDLE);
    assign accept        = bus.in_valid && bus.in_ready;

    // Sequencer: latch operands, step one nibble per cycle, hold result until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            k        <= '0;
            carry    <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            cout_reg <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        // Subtraction is folded in here: store ~B and force carry-in to 1
                        a_reg <= bus.in_a;
                        b_reg <= sub ? ~bus.in_b : bus.in_b;
                        carry <= sub ? 1'b1 : bus.in_cin;
                        k     <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_reg[{k, 2'b00} +: 4] <= adder_sum;
                    carry                    <= adder_cout;
                    if (k == K_LAST) begin
                        cout_reg <= adder_cout;
                        k        <= '0;
                        state    <= S_DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Adder operands come from registers only and are zeroed outside RUN
    always_comb begin
        adder_a   = 4'd0;
        adder_b   = 4'd0;
        adder_cin = 1'b0;
        if (state == S_RUN) begin
            adder_a   = a_reg[{k, 2'b00} +: 4];
            adder_b   = b_reg[{k, 2'b00} +: 4];
            adder_cin = carry;
        end
    end
endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Directed bench for nibble_add_sequencer (WIDTH=16) with a behavioural 4-bit adder.
// Build with NAS_SUB_EN defined to also exercise subtraction.
module tb_nibble_add_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] adder_a, adder_b, adder_sum;
    logic       adder_cin, adder_cout, busy;
    int         errors = 0;
    int         checks = 0;

    nibble_add_sequencer_if #(.WIDTH(16)) bus ();

    nibble_add_sequencer #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .adder_a    (adder_a),
        .adder_b    (adder_b),
        .adder_cin  (adder_cin),
        .adder_sum  (adder_sum),
        .adder_cout (adder_cout),
        .busy       (busy)
    );

    // External shared 4-bit full adder
    assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {4'd0, adder_cin};

    always #5 clk = ~clk;

    task automatic drive_idle();
        bus.in_valid  = 1'b0;
        bus.in_a      = 16'h0;
        bus.in_b      = 16'h0;
        bus.in_cin    = 1'b0;
`ifdef NAS_SUB_EN
        bus.op_sub    = 1'b0;
`endif
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready_low: got %0b want 0", bus.in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.in_ready, bus.out_valid, busy, bus.out_sum, bus.out_cout, adder_a, adder_b, adder_cin}
            !== {1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 4'h0, 4'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: rdy=%0b vld=%0b busy=%0b sum=%h cout=%0b a=%h b=%h cin=%0b want 1 0 0 0000 0 0 0 0",
                     bus.in_ready, bus.out_valid, busy, bus.out_sum, bus.out_cout, adder_a, adder_b, adder_cin);
        end
    endtask

    // One operation: accept, check every pass, optional stall, then result handshake
    task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub, input logic [3:0] cins,
                          input logic [15:0] es, input logic ec, input int hold);
        logic [15:0] bx;
        bx = sub ? ~b : b;
        @(negedge clk);
        bus.in_a = a; bus.in_b = b; bus.in_cin = cin; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
`ifdef NAS_SUB_EN
        bus.op_sub = sub;
`endif
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_in_ready: got %0b want 1", name, bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int p = 0; p < 4; p++) begin
            if (p > 0) @(negedge clk);
            checks++;
            if ({bus.out_valid, busy, bus.in_ready, adder_a, adder_b, adder_cin}
                !== {1'b0, 1'b1, 1'b0, a[4*p +: 4], bx[4*p +: 4], cins[p]}) begin
                errors++;
                $display("FAIL %s_pass%0d: vld=%0b busy=%0b rdy=%0b a=%h b=%h cin=%0b want 0 1 0 %h %h %0b",
                         name, p, bus.out_valid, busy, bus.in_ready, adder_a, adder_b, adder_cin,
                         a[4*p +: 4], bx[4*p +: 4], cins[p]);
            end
        end
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.out_sum, bus.out_cout, adder_a, adder_b, adder_cin}
            !== {1'b1, es, ec, 4'h0, 4'h0, 1'b0}) begin
            errors++;
            $display("FAIL %s_result: vld=%0b sum=%h cout=%0b adder=%h/%h/%0b want 1 %h %0b 0/0/0",
                     name, bus.out_valid, bus.out_sum, bus.out_cout, adder_a, adder_b, adder_cin, es, ec);
        end
        // Stall: a competing operand is offered and must not be taken
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = 1'b1; bus.in_a = 16'hAAAA; bus.in_b = 16'h5555;
            @(negedge clk);
            checks++;
            if ({bus.out_valid, bus.out_sum, bus.out_cout, bus.in_ready} !== {1'b1, es, ec, 1'b0}) begin
                errors++;
                $display("FAIL %s_stall%0d: vld=%0b sum=%h cout=%0b rdy=%0b want 1 %h %0b 0",
                         name, h, bus.out_valid, bus.out_sum, bus.out_cout, bus.in_ready, es, ec);
            end
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        checks++;
        if ({bus.out_valid, busy, bus.in_ready, bus.out_sum, bus.out_cout} !== {1'b0, 1'b0, 1'b1, es, ec}) begin
            errors++;
            $display("FAIL %s_handshake: vld=%0b busy=%0b rdy=%0b sum=%h cout=%0b want 0 0 1 %h %0b",
                     name, bus.out_valid, busy, bus.in_ready, bus.out_sum, bus.out_cout, es, ec);
        end
    endtask

    task automatic test_add();
        run_op("zero", 16'h0000, 16'h0000, 1'b0, 1'b0, 4'b0000, 16'h0000, 1'b0, 0);
        run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 4'b1110, 16'h0000, 1'b1, 0);
        run_op("alt", 16'h5555, 16'h5555, 1'b1, 1'b0, 4'b0001, 16'hAAAB, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        run_op("b2b0", 16'h1111, 16'h2222, 1'b0, 1'b0, 4'b0000, 16'h3333, 1'b0, 0);
        run_op("b2b1", 16'h8000, 16'h8000, 1'b1, 1'b0, 4'b0001, 16'h0001, 1'b1, 0);
    endtask

    task automatic test_backpressure();
        run_op("bp", 16'h1234, 16'h4321, 1'b0, 1'b0, 4'b0000, 16'h5555, 1'b0, 3);
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        bus.in_a = 16'hFFFF; bus.in_b = 16'hFFFF; bus.in_cin = 1'b0; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.out_valid, busy, bus.in_ready, bus.out_sum, bus.out_cout, adder_a, adder_b, adder_cin}
            !== {1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 4'h0, 4'h0, 1'b0}) begin
            errors++;
            $display("FAIL midrst_state: vld=%0b busy=%0b rdy=%0b sum=%h cout=%0b adder=%h/%h/%0b want 0 0 0 0000 0 0/0/0",
                     bus.out_valid, busy, bus.in_ready, bus.out_sum, bus.out_cout, adder_a, adder_b, adder_cin);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_in_ready: got %0b want 1", bus.in_ready);
        end
        run_op("after_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 4'b0110, 16'h0100, 1'b0, 0);
    endtask

`ifdef NAS_SUB_EN
    task automatic test_sub();
        run_op("sub_pos", 16'h1234, 16'h0235, 1'b0, 1'b1, 4'b0001, 16'h0FFF, 1'b1, 0);
        run_op("sub_neg", 16'h0000, 16'h0001, 1'b0, 1'b1, 4'b0001, 16'hFFFF, 1'b0, 0);
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_run();
`ifdef NAS_SUB_EN
        test_sub();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
